// File: rtl/mul_div_unit_if.sv
// Command/result bundle between EX-stage control and the multiply/divide unit.
// Latency: none (wires only); the unit behind the slave modport defines timing.
// Backpressure: Busy tells the hazard unit to stall; the MDU never queues commands.
//
// Signals:
//   Start    launch the operation selected by MDOp (one-cycle pulse)
//   MDOp     00 mult, 01 multu, 10 div, 11 divu
//   Write    mthi/mtlo write strobe, WriteSel 0 = HI, 1 = LO
//   A, B     rs/rt operands (A is also mthi/mtlo data)
//   ReadSel  0 = HI, 1 = LO, selects what OP shows
//   OP       current HI or LO
//   Busy     operation in flight
interface mul_div_unit_if;
    logic        Start;
    logic [1:0]  MDOp;
    logic        Write;
    logic        WriteSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadSel;
    logic [31:0] OP;
    logic        Busy;

    modport master (
        output Start, MDOp, Write, WriteSel, A, B, ReadSel,
        input  OP, Busy
    );

    modport slave (
        input  Start, MDOp, Write, WriteSel, A, B, ReadSel,
        output OP, Busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit beside the ALU: mult/multu/div/divu plus HI/LO (mfhi/mflo/mthi/mtlo).
// Latency: Busy for MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles after Start; new HI/LO on OP the cycle after.
// Backpressure: Start/Write while Busy are dropped; the hazard unit must stall on Busy.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any operation in flight
//   mdu      mul_div_unit_if.slave (Start, MDOp, Write, WriteSel, A, B, ReadSel -> OP, Busy)
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    mul_div_unit_if.slave mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    // Result candidates computed from the latched operands; committed on the last Busy edge.
    logic [31:0]        hi_d;
    logic [31:0]        lo_d;

    //------------------------------------------------------------------
    // Multiply: both products are 64 bits wide; the signed one uses
    // sign-extended operands so the low 64 bits are the exact result.
    //------------------------------------------------------------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    //------------------------------------------------------------------
    // Divide: work on magnitudes, then restore signs. Quotient sign is
    // the XOR of operand signs (truncation toward zero), remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out naturally:
    // magnitude 0x80000000, positive sign, bit pattern 0x80000000.
    //------------------------------------------------------------------
    logic        div_signed;
    logic        div_by_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [31:0] quo;
    logic [31:0] rem;

    assign div_signed  = ~op_q[0];
    assign div_by_zero = (b_q == 32'd0);
    assign a_neg       = div_signed & a_q[31];
    assign b_neg       = div_signed & b_q[31];
    assign div_a       = a_neg ? (~a_q + 32'd1) : a_q;
    // Divisor forced to 1 on zero so the divider never sees 0; the result is discarded anyway.
    assign div_b       = div_by_zero ? 32'd1 : (b_neg ? (~b_q + 32'd1) : b_q);
    assign uquo        = div_a / div_b;
    assign urem        = div_a % div_b;
    assign quo         = (a_neg ^ b_neg) ? (~uquo + 32'd1) : uquo;
    assign rem         = a_neg ? (~urem + 32'd1) : urem;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            MD_MULT: begin
                hi_d = prod_s[63:32];
                lo_d = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_d = prod_u[63:32];
                lo_d = prod_u[31:0];
            end
            default: begin
                // Division by zero leaves HI/LO untouched.
                if (!div_by_zero) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        endcase
    end

    //------------------------------------------------------------------
    // Control FSM with HI/LO and operand registers.
    // The counter is loaded with the full latency and the edge that
    // sees it at 1 is the commit edge, giving exactly N Busy cycles.
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu.Start) begin
                        // Start wins over a simultaneous Write.
                        op_q    <= mdu.MDOp;
                        a_q     <= mdu.A;
                        b_q     <= mdu.B;
                        cnt_q   <= mdu.MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end else if (mdu.Write) begin
                        if (mdu.WriteSel) begin
                            lo_q <= mdu.A;
                        end else begin
                            hi_q <= mdu.A;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.OP   = mdu.ReadSel ? lo_q : hi_q;
    assign mdu.Busy = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner-case sequences,
// randomized operations against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit_if mdu_if ();

    mul_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu     (mdu_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural HI/LO as the bench expects them.
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic. SV '/' truncates toward zero and
    // '%' takes the dividend's sign, which is exactly the div definition.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint          sa, sb, q, m;
        longint unsigned ua, ub, uq, um;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = {hi, lo};
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: if (b != 32'd0) begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
            default: if (b != 32'd0) begin
                uq = ua / ub;
                um = ua % ub;
                r  = {um[31:0], uq[31:0]};
            end
        endcase
        return r;
    endfunction

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        mdu_if.ReadSel = 1'b0;
        #1;
        h = mdu_if.OP;
        mdu_if.ReadSel = 1'b1;
        #1;
        l = mdu_if.OP;
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] d);
        mdu_if.Write    = 1'b1;
        mdu_if.WriteSel = sel;
        mdu_if.A        = d;
        @(posedge clk); #1;
        mdu_if.Write    = 1'b0;
        if (sel) lo_m = d;
        else     hi_m = d;
    endtask

    // Called just after a rising edge. Launches one operation, counts Busy
    // cycles (bounded), checks OP holds the old HI/LO throughout, then checks
    // the committed result in the first cycle after Busy drops.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit with_write, input bit poke);
        logic [31:0] h, l;
        int          cycles;
        bit          stale_ok;
        mdu_if.Start    = 1'b1;
        mdu_if.MDOp     = op;
        mdu_if.A        = a;
        mdu_if.B        = b;
        mdu_if.Write    = with_write;
        mdu_if.WriteSel = 1'b0;
        @(posedge clk); #1;
        mdu_if.Start = 1'b0;
        mdu_if.Write = 1'b0;
        mdu_if.A     = $urandom;
        mdu_if.B     = $urandom;
        cycles   = 0;
        stale_ok = 1'b1;
        while (mdu_if.Busy === 1'b1 && cycles < 64) begin
            cycles++;
            if (poke && cycles == 2) begin
                mdu_if.Start    = 1'b1;
                mdu_if.MDOp     = ~op;
                mdu_if.Write    = 1'b1;
                mdu_if.WriteSel = 1'b1;
            end else begin
                mdu_if.Start = 1'b0;
                mdu_if.Write = 1'b0;
            end
            read_hilo(h, l);
            if (h !== hi_m || l !== lo_m) stale_ok = 1'b0;
            @(posedge clk); #1;
        end
        mdu_if.Start = 1'b0;
        mdu_if.Write = 1'b0;
        check({name, "_stale"}, {31'd0, stale_ok}, 32'd1);
        check({name, "_busy_cycles"}, cycles, op[1] ? DIV_N : MULT_N);
        read_hilo(h, l);
        check({name, "_hi"}, h, exp_hi);
        check({name, "_lo"}, l, exp_lo);
        hi_m = exp_hi;
        lo_m = exp_lo;
    endtask

    initial begin
        logic [31:0] h, l;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;

        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

        mdu_if.Start    = 1'b0;
        mdu_if.MDOp     = 2'b00;
        mdu_if.Write    = 1'b0;
        mdu_if.WriteSel = 1'b0;
        mdu_if.A        = 32'd0;
        mdu_if.B        = 32'd0;
        mdu_if.ReadSel  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, mdu_if.Busy}, 32'd0);
        read_hilo(h, l);
        check("reset_hi", h, 32'd0);
        check("reset_lo", l, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", {31'd0, mdu_if.Busy}, 32'd0);

        // Directed vectors, issued back to back.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);
        end

        // mthi/mtlo visible the next cycle.
        write_reg(1'b1, 32'h0000_1234);
        read_hilo(h, l);
        check("mtlo_1234", l, 32'h0000_1234);
        write_reg(1'b0, 32'h0000_0011);
        write_reg(1'b1, 32'h0000_0022);
        read_hilo(h, l);
        check("mthi_11", h, 32'h0000_0011);
        check("mtlo_22", l, 32'h0000_0022);

        // Divide by zero with a simultaneous Write to HI: HI/LO keep 0x11/0x22.
        run_op("div0_with_write", 2'b10, 32'h0000_0055, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0);
        // divu by zero with Start/Write pulsed mid-Busy.
        run_op("divu0_poke", 2'b11, 32'h0000_0099, 32'd0, 32'h11, 32'h22, 1'b0, 1'b1);
        // mult with Start/Write pulsed mid-Busy and operands scrambled after Start.
        run_op("mult_poke", 2'b00, 32'h0000_0010, 32'h0000_0020, 32'd0, 32'h200, 1'b0, 1'b1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                write_reg(1'($urandom_range(0, 1)), $urandom);
                read_hilo(h, l);
                check($sformatf("rnd%0d_wr_hi", i), h, hi_m);
                check($sformatf("rnd%0d_wr_lo", i), l, lo_m);
            end
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            exp = ref_result(op, a, b, hi_m, lo_m);
            run_op($sformatf("rnd%0d", i), op, a, b, exp[63:32], exp[31:0], 1'b0, 1'b0);
        end

        // Reset mid-Busy: async clear, no late commit after release.
        write_reg(1'b0, 32'h0000_AAAA);
        write_reg(1'b1, 32'h0000_BBBB);
        mdu_if.Start = 1'b1;
        mdu_if.MDOp  = 2'b10;
        mdu_if.A     = 32'd100;
        mdu_if.B     = 32'd7;
        @(posedge clk); #1;
        mdu_if.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_busy", {31'd0, mdu_if.Busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, mdu_if.Busy}, 32'd0);
        read_hilo(h, l);
        check("abort_hi", h, 32'd0);
        check("abort_lo", l, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        repeat (DIV_N + 3) @(posedge clk);
        #1;
        check("abort_after_busy", {31'd0, mdu_if.Busy}, 32'd0);
        read_hilo(h, l);
        check("abort_after_hi", h, 32'd0);
        check("abort_after_lo", l, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
